// File: rtl/alu_pkg.sv
// Shared ALU definitions: one-hot operation codes and datapath widths used by all ALU slices.
package alu_pkg;

  localparam int unsigned OperandWidth = 5;
  localparam int unsigned ResultWidth  = 32;

  localparam logic [5:0] OP_ADD  = 6'b000001;
  localparam logic [5:0] OP_SUB  = 6'b000010;
  localparam logic [5:0] OP_MUL  = 6'b000100;
  localparam logic [5:0] OP_CNT1 = 6'b001000;
  localparam logic [5:0] OP_XOR  = 6'b010000;
  localparam logic [5:0] OP_GT   = 6'b100000;

endpackage

// File: rtl/popcount_10.sv
// Combinational ones counter over a 10-bit vector; result range 0..10.
module popcount_10 (
  input  logic [9:0] data_i,
  output logic [3:0] count_o
);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < 10; i++) begin
      count_o = count_o + 4'(data_i[i]);
    end
  end

endmodule

// File: rtl/add_count_cmp_unit.sv
// Registered ALU slice: add, ones-count and greater-of compare selected by one-hot printout.
// All outputs update one cycle after an accepted request.
module add_count_cmp_unit
  import alu_pkg::*;
#(
  parameter int unsigned OPW  = OperandWidth,
  parameter int unsigned RESW = ResultWidth
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [OPW-1:0]  Number1,
  input  logic [OPW-1:0]  Number2,
  input  logic [5:0]      printout,
  output logic            out_valid,
  output logic [RESW-1:0] conclusion,
  output logic            balancebit,
  output logic            equalitybit,
  output logic            sel_err
);

  logic [OPW:0]   sum;
  logic [OPW-1:0] max_val;
  logic           a_gt_b;
  logic [3:0]     ones;

  logic [RESW-1:0] conclusion_d, conclusion_q;
  logic            balance_d, balance_q;
  logic            equal_d, equal_q;
  logic            valid_d, valid_q;
  logic            sel_err_d, sel_err_q;

  assign sum     = {1'b0, Number1} + {1'b0, Number2};
  assign a_gt_b  = Number1 > Number2;
  assign max_val = a_gt_b ? Number1 : Number2;

  // Counter is fixed at 10 bits, matching the two 5-bit operands.
  popcount_10 u_popcount (
    .data_i  ({Number1, Number2}),
    .count_o (ones)
  );

  always_comb begin
    conclusion_d = conclusion_q;
    balance_d    = balance_q;
    equal_d      = equal_q;
    valid_d      = 1'b0;
    sel_err_d    = 1'b0;
    if (in_valid) begin
      valid_d = 1'b1;
      equal_d = (Number1 == Number2);
      case (printout)
        OP_ADD: begin
          conclusion_d = {{(RESW - OPW - 1){1'b0}}, sum};
          balance_d    = sum[OPW];
        end
        OP_CNT1: begin
          conclusion_d = {{(RESW - 4){1'b0}}, ones};
          balance_d    = ones[0];
        end
        OP_GT: begin
          conclusion_d = {{(RESW - OPW){1'b0}}, max_val};
          balance_d    = a_gt_b;
        end
        // Codes owned by other slices, zero and multi-hot: keep result, flag it.
        default: sel_err_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conclusion_q <= '0;
      balance_q    <= 1'b0;
      equal_q      <= 1'b0;
      valid_q      <= 1'b0;
      sel_err_q    <= 1'b0;
    end else begin
      conclusion_q <= conclusion_d;
      balance_q    <= balance_d;
      equal_q      <= equal_d;
      valid_q      <= valid_d;
      sel_err_q    <= sel_err_d;
    end
  end

  assign conclusion  = conclusion_q;
  assign balancebit  = balance_q;
  assign equalitybit = equal_q;
  assign out_valid   = valid_q;
  assign sel_err     = sel_err_q;

endmodule

// File: tb/tb_add_count_cmp_unit.sv
// Directed self-checking bench for add_count_cmp_unit.
// Observed bundle is {out_valid, sel_err, balancebit, equalitybit, conclusion}.
module tb_add_count_cmp_unit;
  import alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [4:0]  Number1;
  logic [4:0]  Number2;
  logic [5:0]  printout;
  logic        out_valid;
  logic [31:0] conclusion;
  logic        balancebit;
  logic        equalitybit;
  logic        sel_err;

  int checks;
  int errors;

  logic [35:0] obs;
  assign obs = {out_valid, sel_err, balancebit, equalitybit, conclusion};

  add_count_cmp_unit #(
    .OPW  (5),
    .RESW (32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .Number1     (Number1),
    .Number2     (Number2),
    .printout    (printout),
    .out_valid   (out_valid),
    .conclusion  (conclusion),
    .balancebit  (balancebit),
    .equalitybit (equalitybit),
    .sel_err     (sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Set inputs on the falling edge, then advance past the next rising edge.
  task automatic drive(input logic v, input logic [4:0] a, input logic [4:0] b,
                       input logic [5:0] op);
    @(negedge clk);
    in_valid = v;
    Number1  = a;
    Number2  = b;
    printout = op;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b1;
    Number1  = 5'd31;
    Number2  = 5'd31;
    printout = OP_ADD;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs !== 36'h0) begin
      errors++;
      $display("FAIL reset_state: got %h want %h", obs, 36'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (obs !== {1'b1, 1'b0, 1'b1, 1'b1, 32'd62}) begin
      errors++;
      $display("FAIL reset_first_result: got %h want %h", obs, {1'b1, 1'b0, 1'b1, 1'b1, 32'd62});
    end
  endtask

  task automatic test_add();
    drive(1'b1, 5'd12, 5'd9, OP_ADD);
    checks++;
    if (obs !== {1'b1, 1'b0, 1'b0, 1'b0, 32'd21}) begin
      errors++;
      $display("FAIL add_12_9: got %h want %h", obs, {1'b1, 1'b0, 1'b0, 1'b0, 32'd21});
    end
    drive(1'b1, 5'd31, 5'd1, OP_ADD);
    checks++;
    if (obs !== {1'b1, 1'b0, 1'b1, 1'b0, 32'd32}) begin
      errors++;
      $display("FAIL add_31_1: got %h want %h", obs, {1'b1, 1'b0, 1'b1, 1'b0, 32'd32});
    end
    drive(1'b1, 5'd7, 5'd7, OP_ADD);
    checks++;
    if (obs !== {1'b1, 1'b0, 1'b0, 1'b1, 32'd14}) begin
      errors++;
      $display("FAIL add_7_7: got %h want %h", obs, {1'b1, 1'b0, 1'b0, 1'b1, 32'd14});
    end
  endtask

  task automatic test_count1();
    drive(1'b1, 5'b10110, 5'b00011, OP_CNT1);
    checks++;
    if (obs !== {1'b1, 1'b0, 1'b1, 1'b0, 32'd5}) begin
      errors++;
      $display("FAIL cnt_mixed: got %h want %h", obs, {1'b1, 1'b0, 1'b1, 1'b0, 32'd5});
    end
    drive(1'b1, 5'd31, 5'd31, OP_CNT1);
    checks++;
    if (obs !== {1'b1, 1'b0, 1'b0, 1'b1, 32'd10}) begin
      errors++;
      $display("FAIL cnt_all_ones: got %h want %h", obs, {1'b1, 1'b0, 1'b0, 1'b1, 32'd10});
    end
    drive(1'b1, 5'd0, 5'd0, OP_CNT1);
    checks++;
    if (obs !== {1'b1, 1'b0, 1'b0, 1'b1, 32'd0}) begin
      errors++;
      $display("FAIL cnt_zero: got %h want %h", obs, {1'b1, 1'b0, 1'b0, 1'b1, 32'd0});
    end
  endtask

  task automatic test_greater();
    drive(1'b1, 5'd20, 5'd3, OP_GT);
    checks++;
    if (obs !== {1'b1, 1'b0, 1'b1, 1'b0, 32'd20}) begin
      errors++;
      $display("FAIL gt_20_3: got %h want %h", obs, {1'b1, 1'b0, 1'b1, 1'b0, 32'd20});
    end
    drive(1'b1, 5'd3, 5'd20, OP_GT);
    checks++;
    if (obs !== {1'b1, 1'b0, 1'b0, 1'b0, 32'd20}) begin
      errors++;
      $display("FAIL gt_3_20: got %h want %h", obs, {1'b1, 1'b0, 1'b0, 1'b0, 32'd20});
    end
    drive(1'b1, 5'd9, 5'd9, OP_GT);
    checks++;
    if (obs !== {1'b1, 1'b0, 1'b0, 1'b1, 32'd9}) begin
      errors++;
      $display("FAIL gt_9_9: got %h want %h", obs, {1'b1, 1'b0, 1'b0, 1'b1, 32'd9});
    end
  endtask

  task automatic test_unsupported();
    drive(1'b1, 5'd12, 5'd9, OP_ADD);
    drive(1'b1, 5'd4, 5'd4, OP_XOR);
    checks++;
    if (obs !== {1'b1, 1'b1, 1'b0, 1'b1, 32'd21}) begin
      errors++;
      $display("FAIL unsup_xor: got %h want %h", obs, {1'b1, 1'b1, 1'b0, 1'b1, 32'd21});
    end
    drive(1'b1, 5'd31, 5'd1, OP_ADD);
    drive(1'b1, 5'd3, 5'd5, 6'b001001);
    checks++;
    if (obs !== {1'b1, 1'b1, 1'b1, 1'b0, 32'd32}) begin
      errors++;
      $display("FAIL unsup_multihot: got %h want %h", obs, {1'b1, 1'b1, 1'b1, 1'b0, 32'd32});
    end
    drive(1'b1, 5'd6, 5'd6, 6'b000000);
    checks++;
    if (obs !== {1'b1, 1'b1, 1'b1, 1'b1, 32'd32}) begin
      errors++;
      $display("FAIL unsup_zero: got %h want %h", obs, {1'b1, 1'b1, 1'b1, 1'b1, 32'd32});
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 5'd1, 5'd2, OP_ADD);
    checks++;
    if (obs !== {1'b1, 1'b0, 1'b0, 1'b0, 32'd3}) begin
      errors++;
      $display("FAIL b2b_add: got %h want %h", obs, {1'b1, 1'b0, 1'b0, 1'b0, 32'd3});
    end
    drive(1'b1, 5'd6, 5'd5, OP_GT);
    checks++;
    if (obs !== {1'b1, 1'b0, 1'b1, 1'b0, 32'd6}) begin
      errors++;
      $display("FAIL b2b_gt: got %h want %h", obs, {1'b1, 1'b0, 1'b1, 1'b0, 32'd6});
    end
    // Idle with operands that would change every field if wrongly captured.
    drive(1'b0, 5'd9, 5'd9, OP_ADD);
    checks++;
    if (obs !== {1'b0, 1'b0, 1'b1, 1'b0, 32'd6}) begin
      errors++;
      $display("FAIL idle_hold1: got %h want %h", obs, {1'b0, 1'b0, 1'b1, 1'b0, 32'd6});
    end
    drive(1'b0, 5'd0, 5'd0, 6'b010000);
    checks++;
    if (obs !== {1'b0, 1'b0, 1'b1, 1'b0, 32'd6}) begin
      errors++;
      $display("FAIL idle_hold2: got %h want %h", obs, {1'b0, 1'b0, 1'b1, 1'b0, 32'd6});
    end
  endtask

  task automatic test_mid_reset();
    drive(1'b1, 5'd31, 5'd31, OP_ADD);
    checks++;
    if (obs !== {1'b1, 1'b0, 1'b1, 1'b1, 32'd62}) begin
      errors++;
      $display("FAIL pre_reset: got %h want %h", obs, {1'b1, 1'b0, 1'b1, 1'b1, 32'd62});
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 36'h0) begin
      errors++;
      $display("FAIL async_clear: got %h want %h", obs, 36'h0);
    end
    @(posedge clk);
    #1;
    checks++;
    if (obs !== 36'h0) begin
      errors++;
      $display("FAIL reset_held: got %h want %h", obs, 36'h0);
    end
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    drive(1'b1, 5'd20, 5'd3, OP_GT);
    checks++;
    if (obs !== {1'b1, 1'b0, 1'b1, 1'b0, 32'd20}) begin
      errors++;
      $display("FAIL post_reset: got %h want %h", obs, {1'b1, 1'b0, 1'b1, 1'b0, 32'd20});
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_add();
    test_count1();
    test_greater();
    test_unsupported();
    test_back_to_back();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
